// File: rtl/uncached_write_buffer_if.sv
// uncached_write_buffer_if: store push, load conflict check, sync stall and single-beat write bus of the posted-write buffer
interface uncached_write_buffer_if #(
  parameter int CNT_W = 3
);
  logic             pushValid;
  logic [31:0]      pushAddress;
  logic [31:0]      pushData;
  logic [3:0]       pushByteEnables;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] fillLevel;
  logic [31:0]      checkAddress;
  logic             addressConflict;
  logic             memorySync;
  logic             syncStall;
  logic             requestBus;
  logic             busAccessGranted;
  logic             beginTransactionOut;
  logic [31:0]      addressDataOut;
  logic             endTransactionOut;
  logic [3:0]       byteEnablesOut;
  logic             readNotWriteOut;
  logic             dataValidOut;
  logic [7:0]       burstSizeOut;
  logic             busyIn;
  logic             busErrorIn;
  logic             writeError;
  logic [31:0]      errorAddress;
  modport slave (
    input  pushValid, pushAddress, pushData, pushByteEnables, checkAddress, memorySync,
           busAccessGranted, busyIn, busErrorIn,
    output full, empty, fillLevel, addressConflict, syncStall, requestBus, beginTransactionOut,
           addressDataOut, endTransactionOut, byteEnablesOut, readNotWriteOut, dataValidOut,
           burstSizeOut, writeError, errorAddress
  );
  modport master (
    output pushValid, pushAddress, pushData, pushByteEnables, checkAddress, memorySync,
           busAccessGranted, busyIn, busErrorIn,
    input  full, empty, fillLevel, addressConflict, syncStall, requestBus, beginTransactionOut,
           addressDataOut, endTransactionOut, byteEnablesOut, readNotWriteOut, dataValidOut,
           burstSizeOut, writeError, errorAddress
  );
endinterface

// File: rtl/uncached_write_buffer.sv
// uncached_write_buffer: DEPTH-entry posted-write FIFO draining as single-beat bus writes, with load alias check and sync stall
module uncached_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic                    clock,
  input logic                    reset,
  uncached_write_buffer_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEGIN = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       be_q [DEPTH];
  logic [3:0]       be_d [DEPTH];
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic             push, pop, bus_err, conflict;
  logic             unused_check;
  assign push    = wb.pushValid & ~wb.full;
  assign pop     = state_q == S_END;
  assign bus_err = wb.busErrorIn & (state_q == S_BEGIN | state_q == S_DATA);
  assign unused_check = ^wb.checkAddress[1:0];
  always_comb begin
    state_d = bus_err ? S_END
            : state_q == S_IDLE  ? ((wb.requestBus & wb.busAccessGranted) ? S_BEGIN : S_IDLE)
            : state_q == S_BEGIN ? S_DATA
            : state_q == S_DATA  ? (wb.busyIn ? S_DATA : S_END)
            : S_IDLE;
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    if (push) begin
      addr_d[tail_q] = wb.pushAddress;
      data_d[tail_q] = wb.pushData;
      be_d[tail_q]   = wb.pushByteEnables;
    end
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(push);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d      = bus_err;
    err_addr_d = bus_err ? addr_q[head_q] : err_addr_q;
  end
  // Only the count-wide window starting at head is live; the head stays in it until its END pop.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (CNT_W'(i) < count_q && addr_q[head_q + PTR_W'(i)][31:2] == wb.checkAddress[31:2])
        conflict = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end
  assign wb.full                = count_q == CNT_W'(DEPTH);
  assign wb.empty               = count_q == '0;
  assign wb.fillLevel           = count_q;
  assign wb.addressConflict     = conflict;
  assign wb.syncStall           = wb.memorySync & ~wb.empty;
  assign wb.requestBus          = state_q == S_IDLE & ~wb.empty;
  assign wb.beginTransactionOut = state_q == S_BEGIN;
  assign wb.dataValidOut        = state_q == S_DATA;
  assign wb.endTransactionOut   = state_q == S_END;
  assign wb.addressDataOut      = state_q == S_BEGIN ? {addr_q[head_q][31:2], 2'b00}
                                : state_q == S_DATA  ? data_q[head_q] : '0;
  assign wb.byteEnablesOut      = state_q == S_BEGIN ? be_q[head_q] : '0;
  assign wb.readNotWriteOut     = 1'b0;
  assign wb.burstSizeOut        = '0;
  assign wb.writeError          = err_q;
  assign wb.errorAddress        = err_addr_q;
endmodule

// File: tb/tb_uncached_write_buffer.sv
// tb_uncached_write_buffer: directed scenarios plus random traffic checked against a queue-based transaction model
module tb_uncached_write_buffer;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  uncached_write_buffer_if #(.CNT_W(3)) wb ();
  uncached_write_buffer #(.DEPTH(DEPTH), .CNT_W(3)) dut (.clock(clock), .reset(reset), .wb(wb));
  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_ph = 0;
  bit          exp_err = 0;
  logic [31:0] exp_erraddr = '0;
  int          s_ph;
  logic        s_req, s_begin, s_dv, s_end, s_full, s_empty, s_conf, s_sync, s_werr;
  logic [31:0] s_ad, s_erraddr;
  logic [3:0]  s_be;
  logic [2:0]  s_fill;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit conflict_model(input logic [31:0] a);
    foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wb.pushValid = 1'b1;
    wb.pushAddress = a;
    wb.pushData = d;
    wb.pushByteEnables = be;
  endtask
  // Phase: 0 idle, 1 begin, 2 data, 3 end; checks every output against the queue model, then advances one clock.
  task automatic cycle();
    ent_t h, e;
    bit do_push, do_pop, rst_now, err_now;
    #1;
    s_req = wb.requestBus; s_begin = wb.beginTransactionOut; s_dv = wb.dataValidOut;
    s_end = wb.endTransactionOut; s_full = wb.full; s_empty = wb.empty; s_conf = wb.addressConflict;
    s_sync = wb.syncStall; s_werr = wb.writeError; s_ad = wb.addressDataOut;
    s_erraddr = wb.errorAddress; s_be = wb.byteEnablesOut; s_fill = wb.fillLevel;
    s_ph = s_begin ? 1 : s_dv ? 2 : s_end ? 3 : 0;
    h = '{default: '0};
    if (q.size() != 0) h = q[0];
    chk("phase", s_ph, exp_ph);
    chk("fillLevel", s_fill, q.size());
    chk("empty", s_empty, q.size() == 0);
    chk("full", s_full, q.size() == DEPTH);
    chk("conflict", s_conf, conflict_model(wb.checkAddress));
    chk("syncStall", s_sync, wb.memorySync && q.size() != 0);
    chk("requestBus", s_req, s_ph == 0 && q.size() != 0);
    chk("burstSize", wb.burstSizeOut, 0);
    chk("readNotWrite", wb.readNotWriteOut, 0);
    chk("writeError", s_werr, s_ph == 3 && exp_err);
    chk("errorAddress", s_erraddr, exp_erraddr);
    chk("addressData", s_ad, s_ph == 1 ? {h.addr[31:2], 2'b00} : s_ph == 2 ? h.data : 32'h0);
    chk("byteEnables", s_be, s_ph == 1 ? h.be : 4'h0);
    err_now = wb.busErrorIn && (s_ph == 1 || s_ph == 2);
    exp_ph = s_ph == 0 ? ((q.size() != 0 && wb.busAccessGranted) ? 1 : 0)
           : s_ph == 1 ? (err_now ? 3 : 2)
           : s_ph == 2 ? ((err_now || !wb.busyIn) ? 3 : 2)
           : 0;
    do_push = wb.pushValid && q.size() < DEPTH;
    do_pop = s_ph == 3 && q.size() != 0;
    rst_now = reset;
    e = '{addr: wb.pushAddress, data: wb.pushData, be: wb.pushByteEnables};
    @(posedge clock);
    #1;
    if (rst_now) begin
      q.delete();
      exp_ph = 0;
      exp_err = 0;
      exp_erraddr = '0;
    end else begin
      if (err_now) begin
        exp_err = 1;
        exp_erraddr = h.addr;
      end
      if (do_pop) begin
        void'(q.pop_front());
        exp_err = 0;
      end
      if (do_push) q.push_back(e);
    end
  endtask
  initial begin
    int nb, ndv, nend, nwerr;
    logic [31:0] order [4];
    logic [2:0] last;
    bit seen_end;
    wb.pushValid = 0; wb.pushAddress = 0; wb.pushData = 0; wb.pushByteEnables = 0;
    wb.checkAddress = 0; wb.memorySync = 0; wb.busAccessGranted = 0; wb.busyIn = 0; wb.busErrorIn = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    cycle();
    chk("rst_empty", s_empty, 1);
    chk("rst_fill", s_fill, 0);
    chk("rst_bus", {s_req, s_begin, s_dv, s_end, s_werr, s_full, s_conf, s_sync}, 0);
    wb.busAccessGranted = 1;
    push(32'h40000013, 32'hA5A5A5A5, 4'b1000);
    cycle();
    wb.pushValid = 0;
    cycle(); chk("single_req", s_req, 1);
    cycle(); chk("single_begin", s_begin, 1); chk("single_addr", s_ad, 32'h40000010); chk("single_be", s_be, 4'b1000);
    cycle(); chk("single_dv", s_dv, 1); chk("single_data", s_ad, 32'hA5A5A5A5);
    cycle(); chk("single_end", s_end, 1);
    cycle(); chk("single_empty", s_empty, 1);
    wb.busAccessGranted = 0;
    for (int i = 0; i < 5; i++) begin
      push(32'h40001000 + 32'(i * 16), 32'h1000 + 32'(i), 4'hF);
      cycle();
      if (i == 4) chk("full_at_5th", s_full, 1);
    end
    wb.pushValid = 0;
    cycle(); chk("fill_full", s_full, 1); chk("fill_level4", s_fill, 4);
    wb.busAccessGranted = 1;
    nb = 0; last = 3'd4;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (s_begin) begin
        if (nb < 4) order[nb] = s_ad;
        nb++;
      end
      if (s_fill != last) begin
        chk("fill_step", s_fill, last - 3'd1);
        last = s_fill;
      end
      if (s_empty) break;
    end
    chk("fill_txn_count", nb, 4);
    chk("fill_drained", s_empty, 1);
    for (int j = 0; j < 4; j++) chk("fifo_order", order[j], 32'h40001000 + 32'(j * 16));
    push(32'h40002000, 32'hDEADBEEF, 4'h3);
    cycle();
    wb.pushValid = 0;
    cycle();
    cycle(); chk("busy_begin", s_begin, 1);
    wb.busyIn = 1;
    ndv = 0; nend = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) wb.busyIn = 0;
      cycle();
      ndv += int'(s_dv);
      nend += int'(s_end);
      if (s_dv) chk("busy_data", s_ad, 32'hDEADBEEF);
    end
    chk("busy_dv_cycles", ndv, 4);
    chk("busy_end_pulses", nend, 1);
    wb.busAccessGranted = 0;
    push(32'h40000100, 32'h11112222, 4'hF);
    cycle();
    wb.pushValid = 0;
    wb.checkAddress = 32'h40000102;
    cycle(); chk("conflict_hit", s_conf, 1);
    wb.checkAddress = 32'h40000104;
    cycle(); chk("conflict_miss", s_conf, 0);
    wb.memorySync = 1;
    cycle(); chk("sync_on", s_sync, 1);
    wb.busAccessGranted = 1;
    seen_end = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (seen_end) begin
        chk("sync_after_end", s_sync, 0);
        break;
      end
      chk("sync_held", s_sync, 1);
      if (s_end) seen_end = 1;
    end
    chk("sync_end_seen", seen_end, 1);
    wb.memorySync = 0;
    wb.checkAddress = 0;
    wb.busAccessGranted = 0;
    push(32'h40000200, 32'h22222222, 4'hF); cycle();
    push(32'h40000300, 32'h33333333, 4'h1); cycle();
    wb.pushValid = 0;
    wb.busAccessGranted = 1;
    cycle(); chk("err_req", s_req, 1);
    wb.busErrorIn = 1;
    cycle(); chk("err_begin", s_begin, 1);
    wb.busErrorIn = 0;
    cycle(); chk("err_end", s_end, 1); chk("err_pulse", s_werr, 1); chk("err_addr", s_erraddr, 32'h40000200);
    nwerr = 0; nb = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      nwerr += int'(s_werr);
      if (s_begin) begin
        chk("err_next_addr", s_ad, 32'h40000300);
        nb++;
      end
      if (s_empty) break;
    end
    chk("err_single_pulse", nwerr, 0);
    chk("err_next_drained", nb, 1);
    chk("err_addr_hold", s_erraddr, 32'h40000200);
    wb.busAccessGranted = 0;
    for (int i = 0; i < 3; i++) begin
      push(32'h40003000 + 32'(i * 4), 32'h5000 + 32'(i), 4'hF);
      cycle();
    end
    wb.pushValid = 0;
    wb.busAccessGranted = 1;
    cycle();
    cycle(); chk("rst_mid_begin", s_begin, 1);
    reset = 1;
    cycle(); chk("rst_mid_dv", s_dv, 1);
    reset = 0;
    cycle();
    chk("rst_mid_bus", {s_begin, s_dv, s_end, s_req}, 0);
    chk("rst_mid_ad", s_ad, 0);
    chk("rst_mid_empty", s_empty, 1);
    chk("rst_mid_fill", s_fill, 0);
    cycle(); chk("rst_mid_no_end", s_end, 0);
    for (int k = 0; k < 1500; k++) begin
      wb.pushValid = $urandom_range(0, 1) == 1;
      wb.pushAddress = 32'h40000000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      wb.pushData = $urandom;
      wb.pushByteEnables = 4'($urandom_range(1, 15));
      wb.checkAddress = 32'h40000000 | ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
      wb.memorySync = $urandom_range(0, 2) == 0;
      wb.busAccessGranted = $urandom_range(0, 9) < 7;
      wb.busyIn = $urandom_range(0, 9) < 3;
      wb.busErrorIn = $urandom_range(0, 19) == 0;
      cycle();
    end
    wb.pushValid = 0; wb.memorySync = 0; wb.busyIn = 0; wb.busErrorIn = 0; wb.busAccessGranted = 1;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (s_empty && s_ph == 0) break;
    end
    chk("final_drain", s_empty, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
